// File: rtl/fcpu_pkg.sv
// Shared CPU definitions: widths, opcode constants, the memory access unit
// state type and the load/store opcode classifiers.
package fcpu_pkg;

  localparam int unsigned INSTR_W  = 6;
  localparam int unsigned RSV_ID_W = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CDB_W    = RSV_ID_W + DATA_W;

  localparam logic [INSTR_W-1:0] I_NOP     = 6'h00;
  localparam logic [INSTR_W-1:0] I_ADD     = 6'h01;
  localparam logic [INSTR_W-1:0] I_SUB     = 6'h02;
  localparam logic [INSTR_W-1:0] I_LOAD    = 6'h10;
  localparam logic [INSTR_W-1:0] I_LOADB   = 6'h11;
  localparam logic [INSTR_W-1:0] I_LOADR   = 6'h12;
  localparam logic [INSTR_W-1:0] I_LOADT   = 6'h13;
  localparam logic [INSTR_W-1:0] I_LOADTB  = 6'h14;
  localparam logic [INSTR_W-1:0] I_STORE   = 6'h18;
  localparam logic [INSTR_W-1:0] I_STOREB  = 6'h19;
  localparam logic [INSTR_W-1:0] I_STORER  = 6'h1A;
  localparam logic [INSTR_W-1:0] I_STORET  = 6'h1B;
  localparam logic [INSTR_W-1:0] I_STORETB = 6'h1C;
  localparam logic [INSTR_W-1:0] I_INPUT   = 6'h20;
  localparam logic [INSTR_W-1:0] I_OUTPUT  = 6'h21;

  typedef enum logic [2:0] {
    StIdle,
    StMemWr,
    StMemRd,
    StMemWait,
    StInWait,
    StOutWait,
    StCdb
  } mau_state_t;

  function automatic logic is_load(logic [INSTR_W-1:0] opcode);
    return opcode inside {I_LOAD, I_LOADB, I_LOADR, I_LOADT, I_LOADTB};
  endfunction

  function automatic logic is_store(logic [INSTR_W-1:0] opcode);
    return opcode inside {I_STORE, I_STOREB, I_STORER, I_STORET, I_STORETB};
  endfunction

endpackage

// File: rtl/memory_access_unit.sv
// Executes one memory or byte-I/O request at a time and returns load/input results on the CDB.
// Optional MAU_RANGE_CHECK_EN: loads/stores at or above MEM_DEPTH skip the RAM and set err_range.
module memory_access_unit
  import fcpu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned MEM_DEPTH   = 1 << ADDR_W,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                i_valid,
  input  logic [INSTR_W-1:0]  i_opcode,
  input  logic [RSV_ID_W-1:0] i_rsv_id,
  input  logic [DATA_W-1:0]   i_address,
  input  logic [DATA_W-1:0]   i_data,
  output logic                i_ready,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                io_rx_valid,
  input  logic [7:0]          io_rx_data,
  output logic                io_rx_ready,
  output logic                io_tx_valid,
  output logic [7:0]          io_tx_data,
  input  logic                io_tx_ready,
  output logic [CDB_W-1:0]    o_cdb,
  output logic                o_cdb_valid,
  input  logic                o_cdb_ready,
  output logic                err_range
);

  mau_state_t            state_q, state_d;
  logic [RSV_ID_W-1:0]   rob_q, rob_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [DATA_W-1:0]     result_q, result_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  oor;

  logic                  mem_en_d, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_d;
  logic                  io_rx_ready_d, io_tx_valid_d;
  logic [7:0]            io_tx_data_d;
  logic                  o_cdb_valid_d;
  logic [CDB_W-1:0]      o_cdb_d;

`ifdef MAU_RANGE_CHECK_EN
  localparam logic [DATA_W:0] DepthExt = (DATA_W + 1)'(MEM_DEPTH);
  assign oor = {1'b0, i_address} >= DepthExt;
`else
  logic unused_cfg;
  assign oor        = 1'b0;
  assign unused_cfg = ^{i_address[DATA_W-1:ADDR_W], 32'(MEM_DEPTH)};
`endif

  assign i_ready   = (state_q == StIdle);
  assign err_range = err_q;

  always_comb begin
    state_d  = state_q;
    rob_d    = rob_q;
    addr_d   = addr_q;
    data_d   = data_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          rob_d  = i_rsv_id;
          addr_d = i_address[ADDR_W-1:0];
          data_d = i_data;
          if (is_store(i_opcode)) begin
            if (oor) err_d = 1'b1;
            else     state_d = StMemWr;
          end else if (is_load(i_opcode)) begin
            if (oor) begin
              err_d    = 1'b1;
              result_d = '0;
              state_d  = StCdb;
            end else begin
              state_d = StMemRd;
            end
          end else if (i_opcode == I_INPUT) begin
            state_d = StInWait;
          end else if (i_opcode == I_OUTPUT) begin
            state_d = StOutWait;
          end
        end
      end
      StMemWr: state_d = StIdle;
      StMemRd: begin
        state_d = StMemWait;
        cnt_d   = 3'(MEM_LATENCY);
      end
      StMemWait: begin
        // cnt_q == 1 marks the cycle in which the RAM data is valid
        if (cnt_q == 3'd1) begin
          result_d = mem_rdata;
          state_d  = StCdb;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StInWait: begin
        if (io_rx_valid && io_rx_ready) begin
          result_d = {{(DATA_W-8){1'b0}}, io_rx_data};
          state_d  = StCdb;
        end
      end
      StOutWait: if (io_tx_valid && io_tx_ready) state_d = StIdle;
      StCdb:     if (o_cdb_valid && o_cdb_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they align with the state they belong to;
  // the CDB result is presented one cycle after entering StCdb.
  always_comb begin
    mem_en_d      = (state_d == StMemWr) || (state_d == StMemRd);
    mem_we_d      = (state_d == StMemWr);
    mem_addr_d    = mem_en_d ? addr_d : '0;
    mem_wdata_d   = mem_we_d ? data_d : '0;
    io_rx_ready_d = (state_d == StInWait);
    io_tx_valid_d = (state_d == StOutWait);
    io_tx_data_d  = io_tx_valid_d ? data_d[7:0] : 8'h00;
    o_cdb_valid_d = (state_q == StCdb) && (state_d == StCdb);
    o_cdb_d       = o_cdb_valid_d ? {rob_q, result_q} : '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StIdle;
      rob_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      io_rx_ready <= 1'b0;
      io_tx_valid <= 1'b0;
      io_tx_data  <= '0;
      o_cdb_valid <= 1'b0;
      o_cdb       <= '0;
    end else begin
      state_q     <= state_d;
      rob_q       <= rob_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      mem_en      <= mem_en_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      io_rx_ready <= io_rx_ready_d;
      io_tx_valid <= io_tx_valid_d;
      io_tx_data  <= io_tx_data_d;
      o_cdb_valid <= o_cdb_valid_d;
      o_cdb       <= o_cdb_d;
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit with a 3-cycle RAM model and MEM_DEPTH=256.
module tb_memory_access_unit;
  import fcpu_pkg::*;

  logic                clk = 1'b0;
  logic                nrst = 1'b0;
  logic                i_valid;
  logic [INSTR_W-1:0]  i_opcode;
  logic [RSV_ID_W-1:0] i_rsv_id;
  logic [DATA_W-1:0]   i_address;
  logic [DATA_W-1:0]   i_data;
  logic                i_ready;
  logic                mem_en, mem_we;
  logic [15:0]         mem_addr;
  logic [DATA_W-1:0]   mem_wdata, mem_rdata;
  logic                io_rx_valid, io_rx_ready;
  logic [7:0]          io_rx_data;
  logic                io_tx_valid, io_tx_ready;
  logic [7:0]          io_tx_data;
  logic [CDB_W-1:0]    o_cdb;
  logic                o_cdb_valid, o_cdb_ready;
  logic                err_range;

  always #5 clk = ~clk;

  memory_access_unit #(
    .ADDR_W     (16),
    .MEM_DEPTH  (256),
    .MEM_LATENCY(3)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .i_valid    (i_valid),
    .i_opcode   (i_opcode),
    .i_rsv_id   (i_rsv_id),
    .i_address  (i_address),
    .i_data     (i_data),
    .i_ready    (i_ready),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .io_rx_valid(io_rx_valid),
    .io_rx_data (io_rx_data),
    .io_rx_ready(io_rx_ready),
    .io_tx_valid(io_tx_valid),
    .io_tx_data (io_tx_data),
    .io_tx_ready(io_tx_ready),
    .o_cdb      (o_cdb),
    .o_cdb_valid(o_cdb_valid),
    .o_cdb_ready(o_cdb_ready),
    .err_range  (err_range)
  );

  // RAM model: read data valid three cycles after the enable cycle, poison otherwise
  logic [31:0] ram [0:1023];
  logic [31:0] rd_pipe [0:2];
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr[9:0]] <= mem_wdata;
    rd_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr[9:0]] : 32'hBAD0BAD0;
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
  end
  assign mem_rdata = rd_pipe[2];

  int n_wr = 0, n_en = 0, n_rx = 0, n_tx = 0, n_cdb = 0, n_cdbv = 0;
  always @(posedge clk) begin
    if (mem_en && mem_we)            n_wr   <= n_wr + 1;
    if (mem_en)                      n_en   <= n_en + 1;
    if (io_rx_valid && io_rx_ready)  n_rx   <= n_rx + 1;
    if (io_tx_valid && io_tx_ready)  n_tx   <= n_tx + 1;
    if (o_cdb_valid && o_cdb_ready)  n_cdb  <= n_cdb + 1;
    if (o_cdb_valid)                 n_cdbv <= n_cdbv + 1;
  end

  int n_run = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic issue(input logic [INSTR_W-1:0] op, input logic [RSV_ID_W-1:0] rob,
                       input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] data);
    i_valid   = 1'b1;
    i_opcode  = op;
    i_rsv_id  = rob;
    i_address = addr;
    i_data    = data;
    @(negedge clk);
    i_valid   = 1'b0;
    i_opcode  = I_NOP;
  endtask

  task automatic wait_cdb(output int k);
    k = 0;
    while (!o_cdb_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, w0, e0, c0, r0, t0;
    i_valid = 1'b0; i_opcode = I_NOP; i_rsv_id = '0; i_address = '0; i_data = '0;
    io_rx_valid = 1'b0; io_rx_data = '0; io_tx_ready = 1'b0; o_cdb_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_ctrl", {mem_en, mem_we, io_rx_ready, io_tx_valid, o_cdb_valid, err_range}, '0);
    check("rst_bus", {mem_addr, mem_wdata, io_tx_data}, '0);
    check("rst_cdb", o_cdb, '0);
    check("rst_i_ready", i_ready, 1);
    nrst = 1'b1;
    @(negedge clk);

    // store
    w0 = n_wr;
    issue(I_STORE, 4'd3, 32'h10, 32'hDEADBEEF);
    check("st_strobe", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 16'h0010, 32'hDEADBEEF});
    @(negedge clk);
    check("st_done", {mem_en, mem_we, i_ready}, 3'b001);
    check("st_count", n_wr - w0, 1);

    // load, latency 2+3
    c0 = n_cdb;
    issue(I_LOAD, 4'd5, 32'h10, 32'h0);
    check("ld_strobe", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 16'h0010});
    wait_cdb(k);
    check("ld_latency", k, 5);
    check("ld_cdb", o_cdb, {4'd5, 32'hDEADBEEF});
    @(negedge clk);
    check("ld_release", {o_cdb_valid, i_ready}, 2'b01);
    check("ld_handshakes", n_cdb - c0, 1);

    // CDB backpressure
    o_cdb_ready = 1'b0;
    c0 = n_cdb;
    issue(I_LOAD, 4'd9, 32'h10, 32'h0);
    wait_cdb(k);
    check("bp_latency", k, 5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_hold", {o_cdb_valid, i_ready, o_cdb}, {1'b1, 1'b0, 4'd9, 32'hDEADBEEF});
    end
    o_cdb_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {o_cdb_valid, i_ready}, 2'b01);
    check("bp_handshakes", n_cdb - c0, 1);

    // byte input
    r0 = n_rx;
    c0 = n_cdb;
    issue(I_INPUT, 4'd7, 32'h0, 32'h0);
    check("in_wait", {io_rx_ready, o_cdb_valid, i_ready}, 3'b100);
    repeat (4) @(negedge clk);
    io_rx_valid = 1'b1;
    io_rx_data  = 8'hA5;
    @(negedge clk);
    io_rx_valid = 1'b0;
    io_rx_data  = 8'h00;
    check("in_rdy_drop", io_rx_ready, 0);
    wait_cdb(k);
    check("in_latency", k, 1);
    check("in_cdb", o_cdb, {4'd7, 32'h000000A5});
    @(negedge clk);
    check("in_rx_count", n_rx - r0, 1);
    check("in_handshakes", n_cdb - c0, 1);

    // byte output with stall
    t0 = n_tx;
    c0 = n_cdbv;
    issue(I_OUTPUT, 4'd1, 32'h0, 32'h12345641);
    for (int i = 0; i < 3; i++) begin
      check("out_hold", {io_tx_valid, io_tx_data, i_ready}, {1'b1, 8'h41, 1'b0});
      @(negedge clk);
    end
    io_tx_ready = 1'b1;
    @(negedge clk);
    io_tx_ready = 1'b0;
    check("out_done", {io_tx_valid, i_ready}, 2'b01);
    repeat (3) @(negedge clk);
    check("out_tx_count", n_tx - t0, 1);
    check("out_no_cdb", n_cdbv - c0, 0);

    // unsupported opcode is dropped
    e0 = n_en;
    issue(I_ADD, 4'd2, 32'h10, 32'h0);
    check("bad_op", {i_ready, mem_en, io_rx_ready, io_tx_valid}, 4'b1000);
    @(negedge clk);
    check("bad_op_no_en", n_en - e0, 0);

    // async reset while waiting on the RAM
    issue(I_LOAD, 4'd4, 32'h10, 32'h0);
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    #1;
    check("rst_wait_outs", {mem_en, o_cdb_valid, io_rx_ready, io_tx_valid, i_ready}, 5'b00001);
    c0 = n_cdbv;
    @(negedge clk);
    nrst = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_wait_no_cdb", n_cdbv - c0, 0);

    // async reset while a result is held on the CDB
    o_cdb_ready = 1'b0;
    issue(I_LOAD, 4'd6, 32'h10, 32'h0);
    wait_cdb(k);
    check("rst_cdb_pre", {o_cdb_valid, o_cdb}, {1'b1, 4'd6, 32'hDEADBEEF});
    nrst = 1'b0;
    #1;
    check("rst_cdb_clear", {o_cdb_valid, o_cdb, i_ready}, {1'b0, 36'h0, 1'b1});
    c0 = n_cdbv;
    @(negedge clk);
    nrst = 1'b1;
    o_cdb_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_cdb_no_cdb", n_cdbv - c0, 0);

`ifdef MAU_RANGE_CHECK_EN
    e0 = n_en;
    issue(I_LOAD, 4'd2, 32'h100, 32'h0);
    wait_cdb(k);
    check("oor_latency", k, 1);
    check("oor_cdb", o_cdb, {4'd2, 32'h0});
    check("oor_err", err_range, 1);
    @(negedge clk);
    check("oor_no_en", n_en - e0, 0);
    w0 = n_wr;
    issue(I_STORE, 4'd1, 32'h1000, 32'h11);
    @(negedge clk);
    check("oor_st_no_wr", {n_wr - w0, 32'(i_ready)}, {32'd0, 32'd1});
    issue(I_STORE, 4'd1, 32'h20, 32'h55);
    @(negedge clk);
    check("legal_st_wr", n_wr - w0, 1);
    check("err_sticky", err_range, 1);
`else
    issue(I_STORE, 4'd1, 32'h100, 32'hCAFE0100);
    @(negedge clk);
    issue(I_LOAD, 4'd2, 32'h100, 32'h0);
    wait_cdb(k);
    check("hi_ld_cdb", o_cdb, {4'd2, 32'hCAFE0100});
    check("no_err", err_range, 0);
    @(negedge clk);
    issue(I_LOAD, 4'd3, 32'h0001_0010, 32'h0);
    check("trunc_addr", mem_addr, 16'h0010);
    wait_cdb(k);
    check("trunc_cdb", o_cdb, {4'd3, 32'hDEADBEEF});
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
